// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer driving PC load/inc, imem reads and decode handshake; optional FETCH_CTRL_PERF_EN adds perf counters
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [63:0] pc_q,
    output logic        pc_load,
    output logic [1:0]  pc_inc,
    output logic [63:0] pc_d,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        ir_valid,
    output logic [63:0] ir_data,
    input  logic        ir_ready,
    output logic        fault
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_fetch_wait
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FAULT} state_t;
    state_t state, state_n;
    logic pend_valid, pend_set, pend_clr, ir_latch;
    logic [63:0] pend_target;
    // next-state and Mealy outputs; a redirect always wins over a handshake
    always_comb begin
        state_n = state;
        pc_load = 1'b0;
        pc_inc = 2'b00;
        pc_d = 64'd0;
        imem_req = 1'b0;
        imem_addr = 64'd0;
        ir_valid = 1'b0;
        fault = 1'b0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        ir_latch = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_d = redirect_target;
                end else if (run) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                imem_addr = pc_q;
                if (imem_ack) begin
                    pend_clr = 1'b1;
                    if (redirect_valid || pend_valid) begin
                        pc_load = 1'b1;
                        pc_d = redirect_valid ? redirect_target : pend_target;
                        state_n = run ? FETCH : IDLE;
                    end else begin
                        ir_latch = 1'b1;
                        state_n = (imem_rdata[1:0] != 2'b00) ? ISSUE : FAULT;
                    end
                end else if (redirect_valid) begin
                    pend_set = 1'b1;
                end
            end
            ISSUE: begin
                ir_valid = ~redirect_valid;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_d = redirect_target;
                    state_n = FETCH;
                end else if (ir_ready) begin
                    pc_inc = ir_data[1:0];
                    state_n = run ? FETCH : IDLE;
                end
            end
            FAULT: begin
                fault = 1'b1;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_d = redirect_target;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state, instruction latch and pending-redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ir_data <= 64'd0;
            pend_valid <= 1'b0;
            pend_target <= 64'd0;
        end else begin
            state <= state_n;
            if (ir_latch) ir_data <= imem_rdata;
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_target <= redirect_target;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
        end
    end
`ifdef FETCH_CTRL_PERF_EN
    // issue handshakes and memory stall cycles, wrapping counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= 32'd0;
            perf_fetch_wait <= 32'd0;
        end else begin
            if (state == ISSUE && ir_valid && ir_ready) perf_issued <= perf_issued + 32'd1;
            if (state == FETCH && !imem_ack) perf_fetch_wait <= perf_fetch_wait + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, async-reset sequence and randomized run against a behavioural fetch model
module tb_fetch_ctrl;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, imem_ack = 1'b0, redirect_valid = 1'b0, ir_ready = 1'b0;
    logic [63:0] pc_q = 64'd0, imem_rdata = 64'd0, redirect_target = 64'd0;
    logic pc_load, imem_req, ir_valid, fault;
    logic [1:0] pc_inc;
    logic [63:0] pc_d, imem_addr, ir_data;
    int vectors = 0, miscompares = 0;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_issued, perf_fetch_wait;
`endif

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .pc_q(pc_q),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_d(pc_d),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_ready(ir_ready), .fault(fault)
`ifdef FETCH_CTRL_PERF_EN
        , .perf_issued(perf_issued), .perf_fetch_wait(perf_fetch_wait)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic run, rv;
        logic [63:0] rt;
        logic ack;
        logic [63:0] rd;
        logic rdy;
        logic [63:0] pcq;
        logic ld;
        logic [1:0] inc;
        logic [63:0] pd;
        logic req;
        logic [63:0] addr;
        logic iv;
        logic [63:0] ird;
        logic flt;
    } vec_t;

    task automatic cmp(input string nm, input logic ld, input logic [1:0] inc, input logic [63:0] pd,
                       input logic req, input logic [63:0] addr, input logic iv, input logic [63:0] ird, input logic flt);
        vectors++;
        if ({pc_load, pc_inc, pc_d, imem_req, imem_addr, ir_valid, ir_data, fault} !== {ld, inc, pd, req, addr, iv, ird, flt}) begin
            miscompares++;
            $display("FAIL %s: got ld=%b inc=%b pd=%h req=%b addr=%h iv=%b ird=%h flt=%b, want ld=%b inc=%b pd=%h req=%b addr=%h iv=%b ird=%h flt=%b",
                     nm, pc_load, pc_inc, pc_d, imem_req, imem_addr, ir_valid, ir_data, fault, ld, inc, pd, req, addr, iv, ird, flt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {run, redirect_valid, imem_ack, ir_ready} = 4'b0;
        {pc_q, imem_rdata, redirect_target} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t tbl[24];
    logic m_wait, m_held, m_stuck, hs;
    logic [63:0] m_ir, pc, e_pd, e_ird;
    logic [63:0] pend[$];
    logic e_ld, e_req, e_iv, e_flt, was_wait;
    logic [1:0] e_inc;
    logic [31:0] m_issued, m_waits;

    initial begin
        tbl[0]  = '{0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0,0,'h1000,       0,0,0,0,0,0,0,0};
        tbl[2]  = '{1,0,0,1,'h2,0,'h1000,     0,0,0,1,'h1000,0,0,0};
        tbl[3]  = '{1,0,0,0,0,1,'h1000,       0,2,0,0,0,1,'h2,0};
        tbl[4]  = '{1,0,0,0,0,0,'h1004,       0,0,0,1,'h1004,0,'h2,0};
        tbl[5]  = '{1,1,'h2000,0,0,0,'h1004,  0,0,0,1,'h1004,0,'h2,0};
        tbl[6]  = '{1,0,0,0,0,0,'h1004,       0,0,0,1,'h1004,0,'h2,0};
        tbl[7]  = '{1,0,0,1,'h3,0,'h1004,     1,0,'h2000,1,'h1004,0,'h2,0};
        tbl[8]  = '{1,0,0,1,'h1,0,'h2000,     0,0,0,1,'h2000,0,'h2,0};
        tbl[9]  = '{1,0,0,0,0,0,'h2000,       0,0,0,0,0,1,'h1,0};
        tbl[10] = '{1,0,0,0,0,0,'h2000,       0,0,0,0,0,1,'h1,0};
        tbl[11] = '{1,0,0,0,0,0,'h2000,       0,0,0,0,0,1,'h1,0};
        tbl[12] = '{1,1,'h3000,0,0,1,'h2000,  1,0,'h3000,0,0,0,'h1,0};
        tbl[13] = '{1,0,0,1,'h4,0,'h3000,     0,0,0,1,'h3000,0,'h1,0};
        tbl[14] = '{1,0,0,0,0,0,'h3000,       0,0,0,0,0,0,'h4,1};
        tbl[15] = '{1,1,'h4000,0,0,0,'h3000,  1,0,'h4000,0,0,0,'h4,1};
        tbl[16] = '{1,0,0,0,0,0,'h4000,       0,0,0,1,'h4000,0,'h4,0};
        tbl[17] = '{0,0,0,1,'hB,0,'h4000,     0,0,0,1,'h4000,0,'h4,0};
        tbl[18] = '{0,0,0,0,0,1,'h4000,       0,3,0,0,0,1,'hB,0};
        tbl[19] = '{0,1,'h5000,0,0,0,'h4008,  1,0,'h5000,0,0,0,'hB,0};
        tbl[20] = '{0,0,0,0,0,0,'h5000,       0,0,0,0,0,0,'hB,0};
        tbl[21] = '{1,0,0,0,0,0,'h5000,       0,0,0,0,0,0,'hB,0};
        tbl[22] = '{0,1,'h6000,1,'h1,0,'h5000,1,0,'h6000,1,'h5000,0,'hB,0};
        tbl[23] = '{0,0,0,0,0,0,'h6000,       0,0,0,0,0,0,'hB,0};
        do_reset();
        for (int i = 0; i < 24; i++) begin
            {run, redirect_valid, redirect_target, imem_ack, imem_rdata, ir_ready, pc_q} =
                {tbl[i].run, tbl[i].rv, tbl[i].rt, tbl[i].ack, tbl[i].rd, tbl[i].rdy, tbl[i].pcq};
            @(negedge clk);
            cmp($sformatf("tbl[%0d]", i), tbl[i].ld, tbl[i].inc, tbl[i].pd, tbl[i].req, tbl[i].addr, tbl[i].iv, tbl[i].ird, tbl[i].flt);
            @(posedge clk);
            #1;
        end

        do_reset();
        {m_wait, m_held, m_stuck} = 3'b0;
        m_ir = 64'd0;
        pc = 64'd0;
        pend.delete();
        m_issued = 32'd0;
        m_waits = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            run = ($urandom_range(0, 7) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_target = {$urandom, $urandom};
            ir_ready = $urandom_range(0, 1) == 1;
            imem_ack = m_wait && ($urandom_range(0, 2) == 0);
            imem_rdata = {$urandom, $urandom};
            if (imem_rdata[1:0] == 2'b00 && $urandom_range(0, 4) != 0) imem_rdata[0] = 1'b1;
            pc_q = pc;
            {e_ld, e_inc, e_pd, e_req, e_iv, e_flt, hs} = '0;
            e_ird = m_ir;
            was_wait = m_wait;
            if (m_stuck) begin
                e_flt = 1'b1;
                if (redirect_valid) begin
                    e_ld = 1'b1; e_pd = redirect_target; m_stuck = 1'b0; m_wait = 1'b1;
                end
            end else if (m_held) begin
                e_iv = !redirect_valid;
                if (redirect_valid) begin
                    e_ld = 1'b1; e_pd = redirect_target; m_held = 1'b0; m_wait = 1'b1;
                end else if (ir_ready) begin
                    hs = 1'b1; e_inc = m_ir[1:0]; m_held = 1'b0; m_wait = run;
                end
            end else if (m_wait) begin
                e_req = 1'b1;
                if (imem_ack) begin
                    if (redirect_valid || pend.size() > 0) begin
                        e_ld = 1'b1;
                        e_pd = redirect_valid ? redirect_target : pend[0];
                        m_wait = run;
                    end else begin
                        m_ir = imem_rdata;
                        m_wait = 1'b0;
                        if (imem_rdata[1:0] == 2'b00) m_stuck = 1'b1; else m_held = 1'b1;
                    end
                    pend.delete();
                end else if (redirect_valid) begin
                    pend.delete();
                    pend.push_back(redirect_target);
                end
            end else if (redirect_valid) begin
                e_ld = 1'b1; e_pd = redirect_target;
            end else if (run) begin
                m_wait = 1'b1;
            end
            @(negedge clk);
            cmp($sformatf("rand[%0d]", c), e_ld, e_inc, e_pd, e_req, e_req ? pc : 64'd0, e_iv, e_ird, e_flt);
            if (hs) m_issued++;
            if (was_wait && !imem_ack) m_waits++;
            pc = e_ld ? e_pd : pc + (e_inc == 2'd1 ? 64'd1 : e_inc == 2'd2 ? 64'd4 : e_inc == 2'd3 ? 64'd8 : 64'd0);
            @(posedge clk);
            #1;
        end
`ifdef FETCH_CTRL_PERF_EN
        vectors++;
        if (perf_issued !== m_issued || perf_fetch_wait !== m_waits) begin
            miscompares++;
            $display("FAIL perf_counts: got issued=%0d wait=%0d, want issued=%0d wait=%0d", perf_issued, perf_fetch_wait, m_issued, m_waits);
        end
`endif

        run = 1'b1;
        pc_q = 64'h7000;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_req: got %b want 1", imem_req);
        end
        #1 rst = 1'b1;
        #1;
        cmp("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_CTRL_PERF_EN
        vectors++;
        if (perf_issued !== 32'd0 || perf_fetch_wait !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_rst: got issued=%0d wait=%0d, want 0 0", perf_issued, perf_fetch_wait);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
